// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, sub-word stores done as read-modify-write.
// Optional macro LSU_MISALIGN_CHK_EN rejects misaligned halfword/word accesses.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_op,
  output logic                  mem_rw,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_w,
  input  logic [DATA_WIDTH-1:0] mem_data_r
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t                  st, st_nxt;
  logic                    we_q, uns_q, err_q;
  logic [1:0]              size_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    accept, misalign, req_err;

  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [DATA_WIDTH-1:0] w,
                                                        input logic [1:0] sz,
                                                        input logic uns);
    logic signed [7:0]            b_s;
    logic signed [15:0]           h_s;
    logic signed [DATA_WIDTH-1:0] r_s;
    b_s = w[7:0];
    h_s = w[15:0];
    case (sz)
      2'b00:   r_s = uns ? $signed({{(DATA_WIDTH-8){1'b0}}, w[7:0]})   : DATA_WIDTH'(b_s);
      2'b01:   r_s = uns ? $signed({{(DATA_WIDTH-16){1'b0}}, w[15:0]}) : DATA_WIDTH'(h_s);
      default: r_s = $signed(w);
    endcase
    return r_s;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_merge(input logic [DATA_WIDTH-1:0] w,
                                                        input logic [DATA_WIDTH-1:0] d,
                                                        input logic [1:0] sz);
    case (sz)
      2'b00:   return {w[DATA_WIDTH-1:8], d[7:0]};
      2'b01:   return {w[DATA_WIDTH-1:16], d[15:0]};
      default: return d;
    endcase
  endfunction

`ifdef LSU_MISALIGN_CHK_EN
  assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                    ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_err = (req_size == 2'b11) || misalign;
  assign accept  = req_valid && (st == IDLE);

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE: if (accept) begin
              if (req_err)                          st_nxt = RESP;
              else if (req_we && req_size == 2'b10) st_nxt = WR;
              else                                  st_nxt = RD;
            end
      RD:   st_nxt = we_q ? WR : RESP;
      WR:   st_nxt = RESP;
      RESP: st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      st      <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      st <= st_nxt;
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= req_err;
        if (req_err) rdata_q <= '0;
      end
      // read word arrives mid-RD; stores reuse wdata_q to hold the merged word
      if (st == RD) begin
        if (we_q) wdata_q <= store_merge(mem_data_r, wdata_q, size_q);
        else      rdata_q <= load_extend(mem_data_r, size_q, uns_q);
      end
      if (st == WR) rdata_q <= '0;
    end
  end

  assign req_ready  = (st == IDLE);
  assign resp_valid = (st == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = rdata_q;
  assign mem_op     = (st == RD) || (st == WR);
  assign mem_rw     = (st == WR);
  assign mem_addr   = mem_op ? addr_q : '0;
  assign mem_data_w = (st == WR) ? wdata_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised and directed bench for load_store_unit against a byte-array reference model.
module tb_load_store_unit;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_op;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_w;
  logic [31:0] mem_data_r = '0;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  bit [7:0] mem     [256];
  bit [7:0] ref_mem [256];

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_op(mem_op), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_data_w(mem_data_w), .mem_data_r(mem_data_r)
  );

  always #5 sys_clk = ~sys_clk;

  // Byte-addressed memory: reads and writes take effect on the falling edge
  always @(negedge sys_clk) begin
    if (mem_op && !mem_rw) begin
      rd_cnt     <= rd_cnt + 1;
      mem_data_r <= {mem[mem_addr[7:0] + 8'd3], mem[mem_addr[7:0] + 8'd2],
                     mem[mem_addr[7:0] + 8'd1], mem[mem_addr[7:0]]};
    end
    if (mem_op && mem_rw) begin
      wr_cnt <= wr_cnt + 1;
      mem[mem_addr[7:0]]         <= mem_data_w[7:0];
      mem[mem_addr[7:0] + 8'd1]  <= mem_data_w[15:8];
      mem[mem_addr[7:0] + 8'd2]  <= mem_data_w[23:16];
      mem[mem_addr[7:0] + 8'd3]  <= mem_data_w[31:24];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [7:0] a);
    return {ref_mem[a + 8'd3], ref_mem[a + 8'd2], ref_mem[a + 8'd1], ref_mem[a]};
  endfunction

  function automatic logic [31:0] tb_word(input logic [7:0] a);
    return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
  endfunction

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata_o);
    bit          err;
    int          nbytes, exp_lat, exp_rd, exp_wr, lat, r0, w0;
    logic [31:0] mask, exp_rdata;
    logic [7:0]  ai;
    bit          got;
    err = (size == 2'b11);
`ifdef LSU_MISALIGN_CHK_EN
    err = err || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
`endif
    nbytes    = 1 << size;
    exp_rdata = '0;
    if (err) begin
      exp_lat = 1; exp_rd = 0; exp_wr = 0;
    end else if (!we) begin
      mask      = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
      exp_rdata = ref_word(addr[7:0]) & mask;
      if (!uns && exp_rdata[8 * nbytes - 1]) exp_rdata = exp_rdata | ~mask;
      exp_lat = 2; exp_rd = 1; exp_wr = 0;
    end else begin
      for (int i = 0; i < nbytes; i++) begin
        ai = addr[7:0] + 8'(i);
        ref_mem[ai] = wdata[8 * i +: 8];
      end
      exp_lat = (nbytes == 4) ? 2 : 3;
      exp_rd  = (nbytes == 4) ? 0 : 1;
      exp_wr  = 1;
    end

    chk("ready_before", 32'(req_ready), 32'd1);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    r0 = rd_cnt; w0 = wr_cnt;
    @(posedge sys_clk);
    lat = 0; got = 1'b0;
    while (!got && lat < 8) begin
      lat++;
      #1;
      // junk on the request side while busy must be ignored
      req_valid = 1'($urandom); req_we = 1'($urandom); req_size = 2'($urandom);
      req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
      if (resp_valid) got = 1'b1;
      else @(posedge sys_clk);
    end
    rdata_o = resp_rdata;
    if (!got) begin
      chk("resp_timeout", 32'd0, 32'd1);
    end else begin
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("resp_err", 32'(resp_err), 32'(err));
      chk("resp_rdata", resp_rdata, exp_rdata);
      chk("rd_strobes", 32'(rd_cnt - r0), 32'(exp_rd));
      chk("wr_strobes", 32'(wr_cnt - w0), 32'(exp_wr));
      chk("ready_in_resp", 32'(req_ready), 32'd0);
    end
    @(posedge sys_clk);
    #1;
    req_valid = 1'b0;
    chk("resp_one_cycle", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    int          w0, diffs, sel;
    logic [1:0]  sz;

    // reset state
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_mem_op", 32'(mem_op), 32'd0);
    chk("rst_mem_rw", 32'(mem_rw), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_data_w", mem_data_w, 32'd0);
    sys_rst = 1'b0;
    @(posedge sys_clk);
    #1;

    // word store / load, then byte RMW store
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, r);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, r);
    chk("word_load", r, 32'hDEADBEEF);
    do_req(1'b1, 2'b00, 1'b0, 32'h10, 32'h0000_0055, r);
    chk("store_rdata_zero", r, 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, r);
    chk("byte_rmw", r, 32'hDEADBE55);

    // extension cases
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h0000_80F0, r);
    do_req(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, r);
    chk("byte_signed", r, 32'hFFFF_FFF0);
    do_req(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, r);
    chk("byte_unsigned", r, 32'h0000_00F0);
    do_req(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, r);
    chk("half_signed", r, 32'hFFFF_80F0);

    // reserved size
    do_req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, r);
    chk("err_rdata", r, 32'h0);

    // misaligned word load
    do_req(1'b1, 2'b10, 1'b0, 32'h24, 32'hA5B6C7D8, r);
    do_req(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, r);
`ifdef LSU_MISALIGN_CHK_EN
    chk("misaligned_word", r, 32'h0);
`else
    chk("misaligned_word", r, 32'hC7D8_0000);
`endif

    // reset during the read phase of a sub-word store
    req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h10; req_wdata = 32'hAA;
    req_valid = 1'b1;
    w0 = wr_cnt;
    @(posedge sys_clk);
    #1;
    req_valid = 1'b0;
    chk("rd_phase_mem_op", 32'(mem_op), 32'd1);
    #1;
    sys_rst = 1'b1;
    #1;
    chk("rst_abort_mem_op", 32'(mem_op), 32'd0);
    chk("rst_abort_ready", 32'(req_ready), 32'd1);
    chk("rst_abort_resp", 32'(resp_valid), 32'd0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_abort_no_write", 32'(wr_cnt - w0), 32'd0);
    chk("rst_abort_mem", tb_word(8'h10), 32'hDEADBE55);
    chk("rst_abort_idle", 32'(req_ready), 32'd1);

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      sel = int'($urandom_range(0, 9));
      sz  = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
      do_req(1'($urandom), sz, 1'($urandom), 32'($urandom_range(0, 63)), $urandom, r);
    end

    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] != ref_mem[i]) diffs++;
    chk("final_memory", 32'(diffs), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width of requests and memory port.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; only 32 supported.
REQ-003 SHALL have port sys_clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port sys_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  unit idle, request accepted when req_valid && req_ready at rising edge.
REQ-007 SHALL have port req_we  input  1  0=load, 1=store.
REQ-008 SHALL have port req_size  input  2  00=byte, 01=halfword, 10=word, 11=reserved.
REQ-009 SHALL have port req_unsigned  input  1  load zero-extend (1) or sign-extend (0); ignored for stores.
REQ-010 SHALL have port req_addr  input  ADDR_WIDTH  byte address.
REQ-011 SHALL have port req_wdata  input  DATA_WIDTH  store data, right-aligned.
REQ-012 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-013 SHALL have port resp_rdata  output  DATA_WIDTH  extended load result.
REQ-014 SHALL have port resp_err  output  1  request rejected, qualified by resp_valid.
REQ-015 SHALL have port mem_op  output  1  memory operation strobe to downstream byte memory.
REQ-016 SHALL have port mem_rw  output  1  0=read, 1=write.
REQ-017 SHALL have port mem_addr  output  ADDR_WIDTH  memory byte address.
REQ-018 SHALL have port mem_data_w  output  DATA_WIDTH  memory write word, byte 0 at mem_addr.
REQ-019 SHALL have port mem_data_r  input  DATA_WIDTH  memory read word, updated by memory on falling edge of the cycle mem_op=1, mem_rw=0.

Function
REQ-020 SHALL implement states IDLE, RD, WR, RESP; req_ready=1 only in IDLE.
REQ-021 SHALL, on acceptance, latch we/size/unsigned/addr/wdata; next state: RESP if error, WR if word store, else RD.
REQ-022 SHALL in RD drive mem_op=1, mem_rw=0, mem_addr=latched addr for exactly one cycle; next state RESP for load, WR for store.
REQ-023 SHALL at end of RD for a load capture mem_data_r[7:0] (byte) or [15:0] (half) or [31:0] (word), sign- or zero-extended per req_unsigned, into resp_rdata.
REQ-024 SHALL at end of RD for a sub-word store merge req_wdata low byte/halfword into the low lane(s) of mem_data_r, keeping upper bytes (read-modify-write).
REQ-025 SHALL in WR drive mem_op=1, mem_rw=1, mem_addr, mem_data_w=merged (or full) word for exactly one cycle; next state RESP.
REQ-026 SHALL in RESP assert resp_valid for one cycle, then return to IDLE; new request accepted no earlier than the following edge.
REQ-027 SHALL give latency (acceptance edge to resp_valid high): load 2 cycles, word store 2, sub-word store 3, error 1.
REQ-028 SHALL drive mem_op=0 in IDLE and RESP; mem_* SHALL derive only from registered state, no combinational path from req_*.
REQ-029 SHALL treat req_size=11 as error: no memory operation, resp_err=1.
REQ-030 SHALL set resp_rdata=0 on store or error responses and hold resp_rdata between responses.
REQ-031 SHALL ignore req_* while not in IDLE.

Reset
REQ-032 SHALL on sys_rst immediately force IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_op=0, mem_rw=0, mem_addr=0, mem_data_w=0.
REQ-033 SHALL, on reset during RD or WR, abandon the operation; no memory write issued after reset deasserts.

Configuration
REQ-034 SHALL, with macro LSU_MISALIGN_CHK_EN defined, treat halfword with addr[0]=1 or word with addr[1:0]!=0 as error (no memory op, resp_err=1).
REQ-035 SHALL, without LSU_MISALIGN_CHK_EN, perform misaligned accesses unchanged (memory is byte-addressed), resp_err only for req_size=11.

Verification
REQ-036 SHALL cover: word store 0xDEADBEEF at 0x10, then word load 0x10 -> one WR strobe, resp_rdata=0xDEADBEEF, latency 2.
REQ-037 SHALL cover: after REQ-036, byte store 0x55 at 0x10, word load -> RD then WR strobe, resp_rdata=0xDEADBE55.
REQ-038 SHALL cover: memory 0x0000_80F0 at 0x20; byte load signed -> 0xFFFFFFF0; byte unsigned -> 0x000000F0; half signed -> 0xFFFF80F0.
REQ-039 SHALL cover: req_size=11 at 0x0 -> resp_valid with resp_err=1 one cycle after acceptance, mem_op never 1.
REQ-040 SHALL cover: word load 0x22 -> resp_err=1 with LSU_MISALIGN_CHK_EN; bytes 0x22..0x25 returned without it.
REQ-041 SHALL cover: sys_rst pulsed during RD of sub-word store to 0x10 -> mem_op=0 immediately, memory word at 0x10 unchanged, req_ready=1.
